// File: rtl/cordic_result_packer_pkg.sv
// Shared word layout for the CORDIC result RAM: field offsets, widths and packing helpers.
// The front-end unpacker reads words built with these same constants.
package cordic_result_packer_pkg;

    localparam int WORD_W  = 48;
    localparam int COMP_W  = 16;
    localparam int RES_W   = 8;
    localparam int TAG_W   = 10;

    localparam int XM_LSB  = 32;
    localparam int XR_LSB  = 24;
    localparam int YM_LSB  = 8;
    localparam int YR_LSB  = 0;

    localparam int QUA_MSB = 9;
    localparam int QUA_LSB = 7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } wr_state_t;

    // Residuals that do not fit in 8 bits clamp to all-ones.
    function automatic logic [RES_W-1:0] sat_residual(input logic [COMP_W-1:0] res);
        if (res[COMP_W-1:RES_W] != 8'h00) begin
            return 8'hFF;
        end else begin
            return res[RES_W-1:0];
        end
    endfunction

    function automatic logic res_saturates(input logic [COMP_W-1:0] res);
        return (res[COMP_W-1:RES_W] != 8'h00);
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [COMP_W-1:0] xm,
        input logic [RES_W-1:0]  xr8,
        input logic [COMP_W-1:0] ym,
        input logic [RES_W-1:0]  yr8
    );
        logic [WORD_W-1:0] word;
        word                   = '0;
        word[XM_LSB +: COMP_W] = xm;
        word[XR_LSB +: RES_W]  = xr8;
        word[YM_LSB +: COMP_W] = ym;
        word[YR_LSB +: RES_W]  = yr8;
        return word;
    endfunction

endpackage

// File: rtl/pack_fifo.sv
// Register FIFO holding packed {address, data} entries; occupancy kept in its own counter.
// Exposes the head and the entry behind it so the writer can issue back-to-back writes.
module pack_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 58
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_head,
    output logic [W-1:0]             o_head_next,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [$clog2(DEPTH):0]   o_level_next
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic [LW-1:0] w_count_nxt;
    logic [PW-1:0] w_rd_ptr_inc;
    logic          w_do_push;
    logic          w_do_pop;

    // Push is refused on a full FIFO even when a pop lands in the same cycle.
    assign w_do_push    = i_push && (r_count != LW'(DEPTH));
    assign w_do_pop     = i_pop && (r_count != '0);
    assign w_rd_ptr_inc = r_rd_ptr + PW'(1);

    assign o_head       = r_mem[r_rd_ptr];
    assign o_head_next  = r_mem[w_rd_ptr_inc];
    assign o_level      = r_count;
    assign o_level_next = w_count_nxt;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + LW'(1);
            2'b01:   w_count_nxt = r_count - LW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/cordic_result_packer.sv
// Packs CORDIC results into 48-bit RAM words, queues them and writes them out
// through a request/acknowledge handshake with sticky drop and saturation flags.
module cordic_result_packer
    import cordic_result_packer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wen,
    input  logic [AW-1:0]          index_cor,
    input  logic [15:0]            XM,
    input  logic [15:0]            YM,
    input  logic [15:0]            XR,
    input  logic [15:0]            YR,
    output logic                   in_ready,
    output logic                   ram_wen,
    output logic [AW-1:0]          ram_addr,
    output logic [WORD_W-1:0]      ram_D,
    input  logic                   ram_ack,
    input  logic                   clr,
    output logic                   ovf,
    output logic                   sat,
    output logic [$clog2(DEPTH):0] level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = AW + WORD_W;

    wr_state_t         r_state;
    wr_state_t         w_state_nxt;
    logic              r_ram_wen;
    logic [AW-1:0]     r_ram_addr;
    logic [WORD_W-1:0] r_ram_D;
    logic              r_in_ready;
    logic              r_ovf;
    logic              r_sat;

    logic              w_ram_wen_nxt;
    logic [AW-1:0]     w_ram_addr_nxt;
    logic [WORD_W-1:0] w_ram_D_nxt;
    logic [RES_W-1:0]  w_xr8;
    logic [RES_W-1:0]  w_yr8;
    logic              w_res_sat;
    logic [EW-1:0]     w_entry;
    logic              w_push;
    logic              w_pop;
    logic [EW-1:0]     w_head;
    logic [EW-1:0]     w_head_next;
    logic [LW-1:0]     w_level;
    logic [LW-1:0]     w_level_next;

    assign w_xr8     = sat_residual(XR);
    assign w_yr8     = sat_residual(YR);
    assign w_res_sat = res_saturates(XR) || res_saturates(YR);
    assign w_entry   = {index_cor, pack_word(XM, w_xr8, YM, w_yr8)};
    assign w_push    = wen && r_in_ready;

    pack_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_data       (w_entry),
        .o_head       (w_head),
        .o_head_next  (w_head_next),
        .o_level      (w_level),
        .o_level_next (w_level_next)
    );

    // Writer FSM: a request stays stable until acked; on ack, a second queued entry follows immediately.
    always_comb begin
        w_state_nxt    = r_state;
        w_ram_wen_nxt  = r_ram_wen;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_D_nxt    = r_ram_D;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_level != '0) begin
                    w_state_nxt                   = ST_REQ;
                    w_ram_wen_nxt                 = 1'b1;
                    {w_ram_addr_nxt, w_ram_D_nxt} = w_head;
                end else begin
                    w_state_nxt   = ST_IDLE;
                    w_ram_wen_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                if (ram_ack) begin
                    w_pop = 1'b1;
                    if (w_level >= LW'(2)) begin
                        w_state_nxt                   = ST_REQ;
                        w_ram_wen_nxt                 = 1'b1;
                        {w_ram_addr_nxt, w_ram_D_nxt} = w_head_next;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_ram_wen_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt   = ST_REQ;
                    w_ram_wen_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_ram_wen_nxt = 1'b0;
            end
        endcase
    end

    // Registered writer outputs, ready flag and sticky flags (a new event beats clr).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ram_wen  <= 1'b0;
            r_ram_addr <= '0;
            r_ram_D    <= '0;
            r_in_ready <= 1'b1;
            r_ovf      <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ram_wen  <= w_ram_wen_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_D    <= w_ram_D_nxt;
            r_in_ready <= (w_level_next != LW'(DEPTH));
            r_ovf      <= (wen && !r_in_ready) || (r_ovf && !clr);
            r_sat      <= (w_push && w_res_sat) || (r_sat && !clr);
        end
    end

    assign in_ready = r_in_ready;
    assign ram_wen  = r_ram_wen;
    assign ram_addr = r_ram_addr;
    assign ram_D    = r_ram_D;
    assign ovf      = r_ovf;
    assign sat      = r_sat;
    assign level    = w_level;

endmodule

// File: tb/tb_cordic_result_packer.sv
// Scoreboard bench for cordic_result_packer: expected words queued at push, checked at each RAM write.
module tb_cordic_result_packer;

    logic        clk;
    logic        reset;
    logic        wen;
    logic [9:0]  index_cor;
    logic [15:0] XM, YM, XR, YR;
    logic        in_ready;
    logic        ram_wen;
    logic [9:0]  ram_addr;
    logic [47:0] ram_D;
    logic        ram_ack;
    logic        clr;
    logic        ovf;
    logic        sat;
    logic [2:0]  level;

    int          errors = 0;
    int          checks = 0;
    int          n_writes = 0;
    logic [57:0] sb[$];

    cordic_result_packer #(.DEPTH(4), .AW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .wen       (wen),
        .index_cor (index_cor),
        .XM        (XM),
        .YM        (YM),
        .XR        (XR),
        .YR        (YR),
        .in_ready  (in_ready),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_D     (ram_D),
        .ram_ack   (ram_ack),
        .clr       (clr),
        .ovf       (ovf),
        .sat       (sat),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [57:0] exp_entry(input logic [9:0] tag, input logic [15:0] xm,
                                              input logic [15:0] xr, input logic [15:0] ym,
                                              input logic [15:0] yr);
        logic [7:0] xr8;
        logic [7:0] yr8;
        xr8 = (xr[15:8] != 8'h00) ? 8'hFF : xr[7:0];
        yr8 = (yr[15:8] != 8'h00) ? 8'hFF : yr[7:0];
        return {tag, xm, xr8, ym, yr8};
    endfunction

    // A write completes at the coming rising edge when ram_wen and ram_ack are both high now.
    always @(negedge clk) begin
        logic [57:0] exp;
        if (reset && ram_wen && ram_ack) begin
            n_writes++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h D=%h, required no write", ram_addr, ram_D);
            end else begin
                exp = sb.pop_front();
                if ({ram_addr, ram_D} !== exp) begin
                    errors++;
                    $display("FAIL write_data: got addr=%h D=%h, required addr=%h D=%h",
                             ram_addr, ram_D, exp[57:48], exp[47:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [9:0] tag, input logic [15:0] xm, input logic [15:0] xr,
                              input logic [15:0] ym, input logic [15:0] yr, input bit accept);
        wen       = 1'b1;
        index_cor = tag;
        XM        = xm;
        XR        = xr;
        YM        = ym;
        YR        = yr;
        if (accept) sb.push_back(exp_entry(tag, xm, xr, ym, yr));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((level != 3'd0 || ram_wen) && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (level != 3'd0 || ram_wen) begin
            errors++;
            $display("FAIL %s_drain_timeout: got level=%0d ram_wen=%b, required 0/0", name, level, ram_wen);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_empty: got %0d pending, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; wen = 1'b0; index_cor = '0; XM = '0; YM = '0; XR = '0; YR = '0;
        ram_ack = 1'b0; clr = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL reset_ram_wen: got %b required 0", ram_wen); end
        checks++; if (ram_addr !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h required 000", ram_addr); end
        checks++; if (ram_D !== 48'h0) begin errors++; $display("FAIL reset_D: got %h required 0", ram_D); end
        checks++; if ({ovf, sat} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b required 00", {ovf, sat}); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", level); end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        int w0;
        w0 = n_writes;
        ram_ack = 1'b1;
        drive_push(10'h2A5, 16'h1234, 16'h0056, 16'hABCD, 16'h00EF, 1'b1);
        step();
        wen = 1'b0;
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d required 1", level); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL single_wen_early: got %b required 0", ram_wen); end
        step();
        checks++; if (ram_wen !== 1'b1) begin errors++; $display("FAIL single_wen: got %b required 1", ram_wen); end
        checks++; if (ram_D !== 48'h1234_56AB_CDEF) begin errors++; $display("FAIL single_D: got %h required 123456abcdef", ram_D); end
        checks++; if (ram_addr !== 10'h2A5) begin errors++; $display("FAIL single_addr: got %h required 2a5", ram_addr); end
        step();
        checks++; if (ram_wen !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL single_done: got wen=%b level=%0d required 0/0", ram_wen, level); end
        checks++; if (n_writes - w0 != 1) begin errors++; $display("FAIL single_count: got %0d writes required 1", n_writes - w0); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL single_sat: got %b required 0", sat); end
    endtask

    task automatic test_saturation();
        ram_ack = 1'b1;
        drive_push(10'h155, 16'h0F0F, 16'h0180, 16'h7777, 16'h0010, 1'b1);
        step();
        wen = 1'b0;
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_set: got %b required 1", sat); end
        step();
        checks++; if (ram_D[31:24] !== 8'hFF || ram_D[7:0] !== 8'h10) begin
            errors++; $display("FAIL sat_fields: got xr8=%h yr8=%h required ff/10", ram_D[31:24], ram_D[7:0]);
        end
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_clr: got %b required 0", sat); end
    endtask

    task automatic test_overflow();
        int w0;
        ram_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready: got %b required 0", in_ready); end
            end
            drive_push(10'h300 + 10'(i), 16'h1000 + 16'(i), 16'h0020 + 16'(i), 16'h2000 + 16'(i), 16'h0030 + 16'(i), i < 4);
            step();
        end
        wen = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d required 4", level); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", ovf); end
        checks++; if (ram_wen !== 1'b1 || ram_addr !== 10'h300) begin
            errors++; $display("FAIL ovf_hold: got wen=%b addr=%h required 1/300", ram_wen, ram_addr);
        end
        w0 = n_writes;
        ram_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ram_wen !== 1'b1) begin errors++; $display("FAIL ovf_b2b_wen%0d: got %b required 1", i, ram_wen); end
            step();
        end
        checks++; if (ram_wen !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL ovf_drained: got wen=%b level=%0d required 0/0", ram_wen, level); end
        checks++; if (n_writes - w0 != 4) begin errors++; $display("FAIL ovf_count: got %0d writes required 4", n_writes - w0); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b required 0", ovf); end
    endtask

    task automatic test_full_pop_drop();
        ram_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(10'h3A0 + 10'(i), 16'h4000 + 16'(i), 16'h0001, 16'h5000 + 16'(i), 16'h0002, 1'b1);
            step();
        end
        wen = 1'b0;
        checks++; if (level !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_level: got level=%0d rdy=%b required 4/0", level, in_ready); end
        drive_push(10'h3FF, 16'hDEAD, 16'h0003, 16'hBEEF, 16'h0004, 1'b0);
        ram_ack = 1'b1;
        clr = 1'b1;
        step();
        wen = 1'b0;
        clr = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop_level: got %0d required 3", level); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_pop_ovf: got %b required 1", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b required 1", in_ready); end
        drain("full_pop");
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int w0;
        logic [2:0] max_lvl;
        w0 = n_writes;
        max_lvl = 3'd0;
        ram_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b required 1", i, in_ready); end
            drive_push(10'((i * 37 + 5) % 1024), 16'($urandom()), 16'($urandom_range(0, 255)),
                       16'($urandom()), 16'($urandom_range(0, 255)), 1'b1);
            step();
            if (level > max_lvl) max_lvl = level;
        end
        wen = 1'b0;
        drain("b2b");
        checks++; if (max_lvl > 3'd2) begin errors++; $display("FAIL b2b_level: got max %0d required <=2", max_lvl); end
        checks++; if (n_writes - w0 != 16) begin errors++; $display("FAIL b2b_count: got %0d writes required 16", n_writes - w0); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b required 0", ovf); end
    endtask

    task automatic test_reset_midwrite();
        int w0;
        bit seen_wen;
        ram_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(10'h0C0 + 10'(i), 16'h6000 + 16'(i), 16'h0011, 16'h7000 + 16'(i), 16'h0022, 1'b1);
            step();
        end
        wen = 1'b0;
        checks++; if (ram_wen !== 1'b1 || level !== 3'd3) begin errors++; $display("FAIL rst_pre: got wen=%b level=%0d required 1/3", ram_wen, level); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (ram_wen !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL rst_async: got wen=%b level=%0d required 0/0", ram_wen, level); end
        checks++; if (in_ready !== 1'b1 || ram_D !== 48'h0) begin errors++; $display("FAIL rst_async_out: got rdy=%b D=%h required 1/0", in_ready, ram_D); end
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        ram_ack = 1'b1;
        w0 = n_writes;
        seen_wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ram_wen) seen_wen = 1'b1;
        end
        checks++; if (seen_wen || n_writes != w0) begin errors++; $display("FAIL rst_no_writes: got wen_seen=%b writes=%0d required 0/0", seen_wen, n_writes - w0); end
        drive_push(10'h1E1, 16'hCAFE, 16'h0099, 16'hF00D, 16'h0100, 1'b1);
        step();
        wen = 1'b0;
        drain("rst_recover");
        checks++; if (n_writes - w0 != 1) begin errors++; $display("FAIL rst_recover_count: got %0d writes required 1", n_writes - w0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_overflow();
        test_full_pop_drop();
        test_back_to_back();
        test_reset_midwrite();
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
